interrupt_ack_sequencer: RTL
============================

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 The module SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- risedBits  in  8  pending valid requests (bit n = IRn)
- vectorBase  in  5  ICW2 T7..T3
- autoEOI  in  1  ICW4 AEOI
- initDone  in  1  ICW sequence complete
- eoiPulse  in  1  one-cycle non-specific EOI from OCW2
- INTA_n  in  1  CPU acknowledge, active-low, synchronous to clk
- INT  out  1  interrupt request to CPU
- resetIRR  out  3  level to clear in the IRR
- resetIRRValid  out  1  one-cycle clear strobe
- inServiceReg  out  8  ISR contents
- dataOut  out  8  vector byte
- dataOutEnable  out  1  data bus drive enable
REQ-003 Parameters SHALL be none; 8086 two-pulse acknowledge mode only.

Function
REQ-004 Priority SHALL be fixed, IR0 highest and IR7 lowest.
REQ-005 The eligible level SHALL be the lowest-index set bit of risedBits, provided that index is strictly below the lowest-index set bit of inServiceReg (any index when ISR = 0).
REQ-006 INTA_n SHALL be registered once (intaPrev); fall = intaPrev & ~INTA_n; rise = ~intaPrev & INTA_n.
REQ-007 The FSM SHALL have states IDLE, REQ, ACK1, WAIT2, ACK2, all transitions on clk.
REQ-008 IDLE: when initDone = 1 and an eligible level exists -> REQ; INT = 1 from the next cycle.
REQ-009 REQ: when no eligible level exists and no fall occurs -> IDLE; INT = 0 next cycle.
REQ-010 REQ, on fall, with an eligible level L: latch L; set inServiceReg[L]; drive resetIRR = L and resetIRRValid = 1 for exactly one cycle; INT = 0; -> ACK1.
REQ-011 REQ, on fall, with no eligible level (spurious): latch L = 7 and the spurious flag; leave ISR unchanged; no resetIRRValid; INT = 0; -> ACK1.
REQ-012 ACK1: on rise -> WAIT2; dataOutEnable stays 0 during the first pulse.
REQ-013 WAIT2: on fall -> ACK2; dataOut = {vectorBase, L} and dataOutEnable = 1 from the next cycle.
REQ-014 ACK2: on rise, dataOutEnable = 0 next cycle; if autoEOI = 1 and not spurious, clear inServiceReg[L]; -> IDLE.
REQ-015 dataOut SHALL hold its last vector when dataOutEnable = 0; it is valid only while dataOutEnable = 1.
REQ-016 eoiPulse SHALL clear the lowest-index set ISR bit; it has no effect when ISR = 0.
REQ-017 Simultaneous events:
- EOI acts on ISR contents before the same-cycle set or AEOI clear.
- If EOI and a set target the same bit, the set wins.
- If EOI and AEOI target the same bit, the bit clears once.
REQ-018 Changes in risedBits after the first fall SHALL NOT alter the latched L or the spurious flag.
REQ-019 initDone = 0 in any state other than IDLE SHALL force IDLE next cycle with INT = 0 and dataOutEnable = 0; ISR is retained.
REQ-020 INTA_n edges in IDLE SHALL be ignored.

Reset
REQ-021 While rst_n = 0, all of the following SHALL hold immediately, with no clock required:
- state = IDLE, intaPrev = 1
- INT = 0, resetIRR = 0, resetIRRValid = 0
- inServiceReg = 8'h00, dataOut = 8'h00, dataOutEnable = 0
- L = 0, spurious = 0
REQ-022 Reset asserted mid-acknowledge SHALL abort the sequence with no vector driven; the first cycle after release starts in IDLE.

Verification
REQ-023 vectorBase = 5'b01000, risedBits = 8'h04, full INTA pair -> INT high; resetIRR = 2 with a one-cycle valid at the first fall; inServiceReg = 8'h04; dataOut = 8'h42 with enable during the second pulse; INT low.
REQ-024 risedBits = 8'h05 -> L = 0, dataOut = 8'h40; after eoiPulse ISR = 0; with 8'h04 still pending, INT re-asserts and the second sequence gives 8'h42.
REQ-025 ISR = 8'h02, risedBits = 8'h08 -> INT stays 0; risedBits = 8'h01 -> INT = 1, and after acknowledge ISR = 8'h03.
REQ-026 risedBits drops to 0 between INT assertion and the first fall -> spurious: dataOut = 8'h47, ISR unchanged, no resetIRRValid.
REQ-027 autoEOI = 1, risedBits = 8'h80 -> dataOut = 8'h47; ISR = 8'h80 during the sequence and 8'h00 after the second rise.
REQ-028 rst_n pulsed low in WAIT2 -> INT = 0, dataOutEnable = 0, ISR = 0; the next INTA_n fall is ignored.

Source files
------------

// File: rtl/interrupt_ack_sequencer.sv
// 8086-style two-pulse interrupt acknowledge sequencer: fixed priority
// (IR0 highest), in-service tracking, vector delivery on the second INTA pulse.
module interrupt_ack_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] risedBits,
  input  logic [4:0] vectorBase,
  input  logic       autoEOI,
  input  logic       initDone,
  input  logic       eoiPulse,
  input  logic       INTA_n,
  output logic       INT,
  output logic [2:0] resetIRR,
  output logic       resetIRRValid,
  output logic [7:0] inServiceReg,
  output logic [7:0] dataOut,
  output logic       dataOutEnable
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK1, S_WAIT2, S_ACK2} state_t;

  state_t     r_state;
  logic       r_intaPrev;
  logic [2:0] r_level;
  logic       r_spurious;

  logic       w_fall;
  logic       w_rise;
  logic [3:0] w_reqIdx;
  logic [3:0] w_isrIdx;
  logic       w_eligible;
  logic [7:0] w_eoiMask;
  logic [7:0] w_setMask;
  logic [7:0] w_aeoiMask;

  assign w_fall = r_intaPrev & ~INTA_n;
  assign w_rise = ~r_intaPrev & INTA_n;

  // Index 8 means "no bit set", so a request is eligible against an empty ISR.
  always_comb begin
    w_reqIdx = 4'd8;
    w_isrIdx = 4'd8;
    for (int unsigned i = 0; i < 8; i++) begin
      if (risedBits[7 - i])    w_reqIdx = 4'(7 - i);
      if (inServiceReg[7 - i]) w_isrIdx = 4'(7 - i);
    end
  end

  assign w_eligible = (w_reqIdx < w_isrIdx);

  always_comb begin
    w_eoiMask  = '0;
    w_setMask  = '0;
    w_aeoiMask = '0;
    if (eoiPulse && (w_isrIdx != 4'd8)) w_eoiMask[w_isrIdx[2:0]] = 1'b1;
    if (initDone) begin
      case (r_state)
        S_REQ:   if (w_fall && w_eligible) w_setMask[w_reqIdx[2:0]] = 1'b1;
        S_ACK2:  if (w_rise && autoEOI && !r_spurious) w_aeoiMask[r_level] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_intaPrev    <= 1'b1;
      r_level       <= '0;
      r_spurious    <= 1'b0;
      INT           <= 1'b0;
      resetIRR      <= '0;
      resetIRRValid <= 1'b0;
      inServiceReg  <= '0;
      dataOut       <= '0;
      dataOutEnable <= 1'b0;
    end else begin
      r_intaPrev    <= INTA_n;
      resetIRRValid <= 1'b0;
      // EOI clears first; a same-cycle set is ORed in afterwards so it wins.
      inServiceReg  <= (inServiceReg & ~w_eoiMask & ~w_aeoiMask) | w_setMask;
      if (!initDone && (r_state != S_IDLE)) begin
        r_state       <= S_IDLE;
        INT           <= 1'b0;
        dataOutEnable <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (initDone && w_eligible) begin
              r_state <= S_REQ;
              INT     <= 1'b1;
            end
          end
          S_REQ: begin
            if (w_fall) begin
              INT     <= 1'b0;
              r_state <= S_ACK1;
              if (w_eligible) begin
                r_level       <= w_reqIdx[2:0];
                r_spurious    <= 1'b0;
                resetIRR      <= w_reqIdx[2:0];
                resetIRRValid <= 1'b1;
              end else begin
                r_level    <= 3'd7;
                r_spurious <= 1'b1;
              end
            end else if (!w_eligible) begin
              INT     <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_ACK1: begin
            if (w_rise) r_state <= S_WAIT2;
          end
          S_WAIT2: begin
            if (w_fall) begin
              r_state       <= S_ACK2;
              dataOut       <= {vectorBase, r_level};
              dataOutEnable <= 1'b1;
            end
          end
          S_ACK2: begin
            if (w_rise) begin
              r_state       <= S_IDLE;
              dataOutEnable <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
